// File: rtl/mux_sel_reg.sv
// -----------------------------------------------------------------------------
// mux_sel_reg
//
// Purpose:
//   Registered N-channel bus selector for the two-mode timer datapath. One of
//   NUM_CH count/display buses is routed to a registered output. Channel
//   changes are requested through a valid/ready handshake, take effect only on
//   a timer tick boundary, and are optionally followed by a blanking interval
//   of BLANK_CYC cycles during which the output is forced to zero. Downstream
//   display logic therefore never sees a torn or mid-count value.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_bus     in   flattened channels, channel k at [k*WIDTH +: WIDTH]
//   req_sel    in   requested channel
//   req_valid  in   request strobe, qualified by req_ready
//   req_ready  out  high only while idle (RUN)
//   tick       in   one-cycle timer boundary strobe
//   freeze     in   holds the output register when high
//   out        out  registered selected bus
//   cur_sel    out  channel currently driving out
//   busy       out  high while a switch is pending or blanking
//   ack        out  one-cycle pulse when a request completes
//   err        out  one-cycle pulse when a request is rejected
// -----------------------------------------------------------------------------
module mux_sel_reg #(
    parameter int WIDTH     = 25,
    parameter int NUM_CH    = 4,
    parameter int SELW      = 4,
    parameter int DEF_CH    = 0,
    parameter int BLANK_CYC = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH*WIDTH-1:0] in_bus,
    input  logic [SELW-1:0]         req_sel,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    tick,
    input  logic                    freeze,
    output logic [WIDTH-1:0]        out,
    output logic [SELW-1:0]         cur_sel,
    output logic                    busy,
    output logic                    ack,
    output logic                    err
);

    // Counter only needs to hold BLANK_CYC; keep at least one bit so the
    // register exists even with blanking disabled.
    localparam int CNTW = (BLANK_CYC > 0) ? $clog2(BLANK_CYC + 1) : 1;

    localparam logic [SELW-1:0] DEF_SEL  = SELW'(DEF_CH);
    localparam logic [SELW:0]   NUM_CH_W = (SELW + 1)'(NUM_CH);
    localparam logic [CNTW-1:0] BLANK_LD = CNTW'(BLANK_CYC);
    localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_PEND  = 2'd1,
        ST_BLANK = 2'd2
    } state_t;

    state_t            state_q;
    logic [SELW-1:0]   cur_sel_q;
    logic [SELW-1:0]   pend_sel_q;
    logic [CNTW-1:0]   cnt_q;
    logic              ack_q;
    logic              err_q;
    logic [WIDTH-1:0]  out_q;
    logic [WIDTH-1:0]  out_d;
    logic              sel_illegal;
    logic [WIDTH-1:0]  cur_data;

    // Channel lookup by explicit compare per legal channel. A select value at
    // or above NUM_CH matches nothing and yields zero, so a non-power-of-two
    // channel count can never slice outside in_bus.
    function automatic logic [WIDTH-1:0] pick_ch(
        input logic [NUM_CH*WIDTH-1:0] bus,
        input logic [SELW-1:0]         sel
    );
        logic [WIDTH-1:0] res;
        res = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (sel == SELW'(k)) begin
                res = bus[k*WIDTH +: WIDTH];
            end
        end
        return res;
    endfunction

    assign sel_illegal = ({1'b0, req_sel} >= NUM_CH_W);
    assign cur_data    = pick_ch(in_bus, cur_sel_q);

    // Control FSM. Blanking counts down from BLANK_CYC; the edge that finds
    // the counter at zero is the one that returns to RUN, raises ack and
    // loads the new channel, so ack and the first new sample coincide. With
    // BLANK_CYC = 0 that edge is the one right after the tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            cur_sel_q  <= DEF_SEL;
            pend_sel_q <= DEF_SEL;
            cnt_q      <= '0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            case (state_q)
                ST_RUN: begin
                    // Any tick in RUN, including one coincident with the
                    // accepted request, is deliberately not used.
                    if (req_valid) begin
                        if (sel_illegal) begin
                            err_q <= 1'b1;
                        end else if (req_sel == cur_sel_q) begin
                            ack_q <= 1'b1;
                        end else begin
                            pend_sel_q <= req_sel;
                            state_q    <= ST_PEND;
                        end
                    end
                end
                ST_PEND: begin
                    // No queueing: req_valid is ignored until back in RUN.
                    if (tick) begin
                        cur_sel_q <= pend_sel_q;
                        cnt_q     <= BLANK_LD;
                        state_q   <= ST_BLANK;
                    end
                end
                ST_BLANK: begin
                    if (cnt_q == '0) begin
                        ack_q   <= 1'b1;
                        state_q <= ST_RUN;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                default: begin
                    state_q <= ST_RUN;
                end
            endcase
        end
    end

    // Output next value. cur_sel_q already holds the new channel while
    // blanking, so the final blanking edge can load it directly.
    always_comb begin
        out_d = cur_data;
        if (state_q == ST_BLANK && cnt_q != '0) begin
            out_d = '0;
        end
    end

    // freeze gates only this register, blanking zeros included.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= '0;
        end else if (!freeze) begin
            out_q <= out_d;
        end
    end

    assign out       = out_q;
    assign cur_sel   = cur_sel_q;
    assign ack       = ack_q;
    assign err       = err_q;
    assign busy      = (state_q != ST_RUN);
    assign req_ready = (state_q == ST_RUN);

endmodule

// File: tb/tb_mux_sel_reg.sv
// -----------------------------------------------------------------------------
// tb_mux_sel_reg
//
// Self-checking bench for mux_sel_reg with default parameters (4 channels of
// 25 bits, two blanking cycles). Straight-through data is driven from a
// vector table and compared via an expected-value queue; switch, reject,
// freeze and asynchronous reset behaviour use hand-written sequences.
// -----------------------------------------------------------------------------
module tb_mux_sel_reg;

    localparam int WIDTH     = 25;
    localparam int NUM_CH    = 4;
    localparam int SELW      = 4;
    localparam int DEF_CH    = 0;
    localparam int BLANK_CYC = 2;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic [NUM_CH*WIDTH-1:0] in_bus;
    logic [SELW-1:0]         req_sel;
    logic                    req_valid;
    logic                    req_ready;
    logic                    tick;
    logic                    freeze;
    logic [WIDTH-1:0]        dout;
    logic [SELW-1:0]         cur_sel;
    logic                    busy;
    logic                    ack;
    logic                    err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0][WIDTH-1:0] ch;
        logic                  frz;
        logic [WIDTH-1:0]      e0;   // expected out with channel 0 selected
        logic [WIDTH-1:0]      e2;   // expected out with channel 2 selected
    } vec_t;

    vec_t             vecs[6];
    logic [WIDTH-1:0] sbq[$];

    always #5 clk = ~clk;

    mux_sel_reg #(
        .WIDTH    (WIDTH),
        .NUM_CH   (NUM_CH),
        .SELW     (SELW),
        .DEF_CH   (DEF_CH),
        .BLANK_CYC(BLANK_CYC)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_bus   (in_bus),
        .req_sel  (req_sel),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .tick     (tick),
        .freeze   (freeze),
        .out      (dout),
        .cur_sel  (cur_sel),
        .busy     (busy),
        .ack      (ack),
        .err      (err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic setch(input int k, input logic [WIDTH-1:0] v);
        in_bus[k*WIDTH +: WIDTH] = v;
    endtask

    task automatic run_table(input bit use_c2);
        logic [WIDTH-1:0] e;
        for (int i = 0; i < 6; i++) begin
            in_bus = vecs[i].ch;
            freeze = vecs[i].frz;
            sbq.push_back(use_c2 ? vecs[i].e2 : vecs[i].e0);
            cyc();
            e = sbq.pop_front();
            chk(use_c2 ? "table_c2" : "table_c0", 32'(dout), 32'(e));
        end
        freeze = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1);
    end

    initial begin
        logic [WIDTH-1:0] v;

        // ch order in the literal is ch3, ch2, ch1, ch0
        vecs[0].ch = {25'h1555555, 25'h0AAAAAA, 25'h1111111, 25'h0000001};
        vecs[0].frz = 1'b0; vecs[0].e0 = 25'h0000001; vecs[0].e2 = 25'h0AAAAAA;
        vecs[1].ch = {25'h1FFFFFF, 25'h0DEADBE, 25'h0000000, 25'h1FFFFFF};
        vecs[1].frz = 1'b0; vecs[1].e0 = 25'h1FFFFFF; vecs[1].e2 = 25'h0DEADBE;
        vecs[2].ch = {25'h0000000, 25'h1F0F0F0, 25'h1234567, 25'h0F0F0F0};
        vecs[2].frz = 1'b1; vecs[2].e0 = 25'h1FFFFFF; vecs[2].e2 = 25'h0DEADBE;
        vecs[3].ch = {25'h0000000, 25'h1654321, 25'h1234567, 25'h0123456};
        vecs[3].frz = 1'b1; vecs[3].e0 = 25'h1FFFFFF; vecs[3].e2 = 25'h0DEADBE;
        vecs[4].ch = {25'h0000000, 25'h1654321, 25'h1234567, 25'h0123456};
        vecs[4].frz = 1'b0; vecs[4].e0 = 25'h0123456; vecs[4].e2 = 25'h1654321;
        vecs[5].ch = {25'h0FFFFFF, 25'h1000000, 25'h0000002, 25'h0000000};
        vecs[5].frz = 1'b0; vecs[5].e0 = 25'h0000000; vecs[5].e2 = 25'h1000000;

        // Reset and default channel
        rst_n = 1'b0; req_sel = '0; req_valid = 1'b0; tick = 1'b0; freeze = 1'b0;
        in_bus = '0;
        setch(0, 25'h1ABCDEF);
        setch(1, 25'h0000011);
        setch(2, 25'h0000022);
        setch(3, 25'h0000033);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out", 32'(dout), 32'h0);
        chk("rst_cur_sel", 32'(cur_sel), 32'(DEF_CH));
        chk("rst_ready", 32'(req_ready), 32'h1);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_ack", 32'(ack), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        rst_n = 1'b1;
        cyc();
        chk("rel_out", 32'(dout), 32'h1ABCDEF);
        chk("rel_cur_sel", 32'(cur_sel), 32'h0);
        chk("rel_ready", 32'(req_ready), 32'h1);

        // Straight-through data on channel 0, including freeze holds
        run_table(1'b0);

        // Normal switch to channel 2; tick coincident with acceptance is unused
        setch(0, 25'h0111111);
        setch(2, 25'h0000123);
        req_sel = 4'd2; req_valid = 1'b1; tick = 1'b1;
        cyc();
        req_valid = 1'b0; tick = 1'b0;
        chk("sw_busy_a", 32'(busy), 32'h1);
        chk("sw_ready_a", 32'(req_ready), 32'h0);
        chk("sw_cur_a", 32'(cur_sel), 32'h0);
        chk("sw_ack_a", 32'(ack), 32'h0);
        cyc();
        chk("sw_pend_out", 32'(dout), 32'h0111111);
        chk("sw_pend_cur", 32'(cur_sel), 32'h0);
        setch(0, 25'h0222222);
        cyc();
        chk("sw_pend_track", 32'(dout), 32'h0222222);
        chk("sw_pend_busy", 32'(busy), 32'h1);
        tick = 1'b1;
        cyc();                                 // edge t
        chk("sw_t_cur", 32'(cur_sel), 32'h2);
        chk("sw_t_out", 32'(dout), 32'h0222222);
        chk("sw_t_busy", 32'(busy), 32'h1);
        cyc();                                 // t+1, tick held high into BLANK
        tick = 1'b0;
        chk("sw_b1_out", 32'(dout), 32'h0);
        chk("sw_b1_ack", 32'(ack), 32'h0);
        chk("sw_b1_busy", 32'(busy), 32'h1);
        cyc();                                 // t+2
        chk("sw_b2_out", 32'(dout), 32'h0);
        chk("sw_b2_ack", 32'(ack), 32'h0);
        chk("sw_b2_busy", 32'(busy), 32'h1);
        cyc();                                 // t+3
        chk("sw_new_out", 32'(dout), 32'h0000123);
        chk("sw_new_ack", 32'(ack), 32'h1);
        chk("sw_new_busy", 32'(busy), 32'h0);
        chk("sw_new_ready", 32'(req_ready), 32'h1);
        cyc();
        chk("sw_ack_drop", 32'(ack), 32'h0);

        // Straight-through data on channel 2
        run_table(1'b1);

        // Illegal selects and same-channel request
        req_sel = 4'd6; req_valid = 1'b1;
        cyc();
        req_valid = 1'b0;
        chk("ill6_err", 32'(err), 32'h1);
        chk("ill6_ack", 32'(ack), 32'h0);
        chk("ill6_busy", 32'(busy), 32'h0);
        chk("ill6_cur", 32'(cur_sel), 32'h2);
        cyc();
        chk("ill6_err_drop", 32'(err), 32'h0);
        chk("ill6_busy2", 32'(busy), 32'h0);
        req_sel = 4'd4; req_valid = 1'b1;
        cyc();
        req_valid = 1'b0;
        chk("ill4_err", 32'(err), 32'h1);
        chk("ill4_busy", 32'(busy), 32'h0);
        cyc();
        chk("ill4_err_drop", 32'(err), 32'h0);
        req_sel = 4'd2; req_valid = 1'b1;
        cyc();
        req_valid = 1'b0;
        chk("same_ack", 32'(ack), 32'h1);
        chk("same_err", 32'(err), 32'h0);
        chk("same_busy", 32'(busy), 32'h0);
        cyc();
        chk("same_ack_drop", 32'(ack), 32'h0);
        chk("same_busy2", 32'(busy), 32'h0);
        chk("same_cur", 32'(cur_sel), 32'h2);

        // Tick while idle does nothing
        tick = 1'b1;
        cyc();
        cyc();
        tick = 1'b0;
        chk("run_tick_cur", 32'(cur_sel), 32'h2);
        chk("run_tick_busy", 32'(busy), 32'h0);
        chk("run_tick_ack", 32'(ack), 32'h0);

        // Traffic while pending is ignored; out keeps tracking channel 2
        setch(0, 25'h0333333);
        req_sel = 4'd0; req_valid = 1'b1;
        cyc();
        req_sel = 4'd1;
        for (int i = 0; i < 20; i++) begin
            v = WIDTH'($urandom);
            setch(2, v);
            sbq.push_back(v);
            cyc();
            chk("ign_ready", 32'(req_ready), 32'h0);
            chk("ign_out", 32'(dout), 32'(sbq.pop_front()));
        end
        chk("ign_cur", 32'(cur_sel), 32'h2);
        req_valid = 1'b0; tick = 1'b1;
        cyc();
        tick = 1'b0;
        chk("ign_pend_sel", 32'(cur_sel), 32'h0);
        cyc();
        chk("ign_b1", 32'(dout), 32'h0);
        cyc();
        chk("ign_b2", 32'(dout), 32'h0);
        cyc();
        chk("ign_new_out", 32'(dout), 32'h0333333);
        chk("ign_new_ack", 32'(ack), 32'h1);

        // Freeze across a full switch to channel 3
        freeze = 1'b1;
        setch(0, 25'h0444444);
        setch(3, 25'h1CAFE00);
        req_sel = 4'd3; req_valid = 1'b1;
        cyc();
        req_valid = 1'b0;
        chk("frz_out_a", 32'(dout), 32'h0333333);
        chk("frz_busy_a", 32'(busy), 32'h1);
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        chk("frz_cur_t", 32'(cur_sel), 32'h3);
        chk("frz_out_t", 32'(dout), 32'h0333333);
        cyc();
        chk("frz_out_b1", 32'(dout), 32'h0333333);
        cyc();
        chk("frz_out_b2", 32'(dout), 32'h0333333);
        cyc();
        chk("frz_ack", 32'(ack), 32'h1);
        chk("frz_out_ack", 32'(dout), 32'h0333333);
        chk("frz_busy_end", 32'(busy), 32'h0);
        freeze = 1'b0;
        cyc();
        chk("frz_release", 32'(dout), 32'h1CAFE00);
        chk("frz_ack_drop", 32'(ack), 32'h0);

        // Asynchronous reset mid-PEND
        req_sel = 4'd1; req_valid = 1'b1;
        cyc();
        req_valid = 1'b0;
        chk("rp_busy", 32'(busy), 32'h1);
        chk("rp_cur", 32'(cur_sel), 32'h3);
        #3;
        rst_n = 1'b0;
        #1;
        chk("rp_out", 32'(dout), 32'h0);
        chk("rp_cur0", 32'(cur_sel), 32'(DEF_CH));
        chk("rp_busy0", 32'(busy), 32'h0);
        chk("rp_ready", 32'(req_ready), 32'h1);
        cyc();
        rst_n = 1'b1;
        setch(0, 25'h0555555);
        cyc();
        chk("rp_rel_out", 32'(dout), 32'h0555555);
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        chk("rp_discard_cur", 32'(cur_sel), 32'h0);
        chk("rp_discard_busy", 32'(busy), 32'h0);

        // Asynchronous reset mid-BLANK
        setch(1, 25'h0ABCDE1);
        req_sel = 4'd1; req_valid = 1'b1;
        cyc();
        req_valid = 1'b0; tick = 1'b1;
        cyc();
        tick = 1'b0;
        cyc();
        chk("rb_out", 32'(dout), 32'h0);
        chk("rb_busy", 32'(busy), 32'h1);
        chk("rb_cur", 32'(cur_sel), 32'h1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("rb_cur0", 32'(cur_sel), 32'(DEF_CH));
        chk("rb_busy0", 32'(busy), 32'h0);
        chk("rb_out0", 32'(dout), 32'h0);
        chk("rb_ack0", 32'(ack), 32'h0);
        cyc();
        rst_n = 1'b1;
        cyc();
        cyc();
        chk("rb_rel_cur", 32'(cur_sel), 32'h0);
        chk("rb_rel_ack", 32'(ack), 32'h0);
        chk("rb_rel_out", 32'(dout), 32'h0555555);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
